// File: rtl/jk_ff.sv
// Clocked JK flip-flop, one independent cell per bit, with two redundant state copies.
// Both copies must stay equal; they reach the same next state through two different formulations.
module jk_ff #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_nbl,
  output logic [WIDTH-1:0] q_bl
);

  logic [WIDTH-1:0] r_q_nbl;
  logic [WIDTH-1:0] r_q_bl;
  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_next_b;

  // Truth-table form of the JK rule for a single bit.
  function automatic logic jk_next(input logic j_bit, input logic k_bit, input logic q_bit);
    logic v;
    case ({j_bit, k_bit})
      2'b00:   v = q_bit;
      2'b01:   v = 1'b0;
      2'b10:   v = 1'b1;
      2'b11:   v = ~q_bit;
      default: v = q_bit;
    endcase
    return v;
  endfunction

  // Copy A next state: per-bit truth table.
  always_comb begin
    w_next_a = r_q_nbl;
    for (int i = 0; i < WIDTH; i++) begin
      w_next_a[i] = jk_next(j[i], k[i], r_q_nbl[i]);
    end
  end

  // Copy B next state: characteristic equation q+ = j&~q | ~k&q.
  always_comb begin
    w_next_b = (j & ~r_q_bl) | (~k & r_q_bl);
  end

  // Copy A state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q_nbl <= RESET_VALUE;
    end else begin
      r_q_nbl <= w_next_a;
    end
  end

  // Copy B state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q_bl <= RESET_VALUE;
    end else begin
      r_q_bl <= w_next_b;
    end
  end

  assign q_nbl = r_q_nbl;
  assign q_bl  = r_q_bl;

endmodule

// File: tb/tb_jk_ff.sv
// Self-checking bench for jk_ff: a 1-bit default instance and a 4-bit instance with reset value 1010.
// A lookup-table model is compared every cycle, and literal expectations pin both model and DUT.
module tb_jk_ff;

  logic       clk;
  logic       rst;
  logic       j1, k1;
  logic [3:0] j4, k4;
  logic       q1_nbl, q1_bl;
  logic [3:0] q4_nbl, q4_bl;

  int n_pass  = 0;
  int n_total = 0;

  // Model state.
  logic       m_valid = 1'b0;
  logic       m1;
  logic [3:0] m4;
  // Next-state table indexed by {j,k,q}.
  logic [7:0] lut = 8'b0111_0010;

  jk_ff u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .j     (j1),
    .k     (k1),
    .q_nbl (q1_nbl),
    .q_bl  (q1_bl)
  );

  jk_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .j     (j4),
    .k     (k4),
    .q_nbl (q4_nbl),
    .q_bl  (q4_bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: reset loads the reset value, otherwise table lookup per bit.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m1      <= 1'b0;
      m4      <= 4'b1010;
      m_valid <= 1'b1;
    end else begin
      m1 <= lut[{j1, k1, m1}];
      for (int i = 0; i < 4; i++) begin
        m4[i] <= lut[{j4[i], k4[i], m4[i]}];
      end
    end
  end

  // Every-cycle comparison against the model once it is defined.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_q1_nbl", {3'b000, q1_nbl}, {3'b000, m1});
      chk("cyc_q1_bl",  {3'b000, q1_bl},  {3'b000, m1});
      chk("cyc_q4_nbl", q4_nbl, m4);
      chk("cyc_q4_bl",  q4_bl,  m4);
    end
  end

  task automatic step(input logic r, input logic jj, input logic kk,
                      input logic [3:0] jj4, input logic [3:0] kk4);
    @(negedge clk);
    #1;
    rst = r; j1 = jj; k1 = kk; j4 = jj4; k4 = kk4;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic e1, input logic [3:0] e4);
    chk({name, "_m1"},  {3'b000, m1},     {3'b000, e1});
    chk({name, "_q1a"}, {3'b000, q1_nbl}, {3'b000, e1});
    chk({name, "_q1b"}, {3'b000, q1_bl},  {3'b000, e1});
    chk({name, "_m4"},  m4,     e4);
    chk({name, "_q4a"}, q4_nbl, e4);
    chk({name, "_q4b"}, q4_bl,  e4);
  endtask

  initial begin
    rst = 1'b0; j1 = 1'b0; k1 = 1'b1; j4 = 4'b0000; k4 = 4'b1111;

    // Reset wins over active inputs.
    step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111); lit("rst_clr", 1'b0, 4'b1010);
    step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111); lit("rst_tgl", 1'b0, 4'b1010);

    // Release: hold on 1-bit, mixed per-bit rules on 4-bit (hold,clear,set,toggle).
    step(1'b1, 1'b0, 1'b0, 4'b0011, 4'b0101); lit("rel_hold", 1'b0, 4'b1011);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000); lit("clr0", 1'b0, 4'b1011);

    // Set, hold twice, clear.
    step(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000); lit("set", 1'b1, 4'b1011);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000); lit("hold1", 1'b1, 4'b1011);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000); lit("hold2", 1'b1, 4'b1011);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000); lit("clr1", 1'b0, 4'b1011);

    // Toggle run: divide-by-2.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111);
      lit($sformatf("tgl%0d", i), (i % 2 == 0) ? 1'b1 : 1'b0,
          (i % 2 == 0) ? 4'b0100 : 4'b1011);
    end

    // Reset mid-toggle, then release while toggling.
    step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111); lit("rst_mid", 1'b0, 4'b1010);
    step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111); lit("rel_tgl", 1'b1, 4'b0101);

    // Glitches between edges on rst/j/k must not disturb state.
    @(negedge clk);
    #1;
    rst = 1'b1; j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    #1;
    rst = 1'b0; k1 = 1'b1; k4 = 4'b1111;
    #2;
    rst = 1'b1; k1 = 1'b0; k4 = 4'b0000;
    @(posedge clk);
    #1;
    lit("glitch", 1'b1, 4'b0101);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
